uart_tx: RTL
============

Name: uart_tx

Overview:
Serial UART transmitter. It is the transmit end of the same link the UART_RX block receives.
- Takes a parallel byte with a valid strobe and serialises it LSB-first as: start bit (0), DATA_WIDTH data bits, optional parity bit, stop bit (1).
- Each bit is held for `prescale` clock cycles, so a TX configured with the same prescale/PAR_EN/PAR_TYP as UART_RX drives it directly.
- Sits between the system data source (FIFO/register file) and the serial line.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input (cycles per bit, up to 63).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- P_DATA  in  DATA_WIDTH  parallel data to send.
- DATA_VALID  in  1  request to send P_DATA. Sampled only when an accept is possible.
- PAR_EN  in  1  1 = parity bit inserted after the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- prescale  in  PRESCALE_W  clock cycles per serial bit. 0 is treated as 1.
- TX_OUT  out  1  serial line, registered; idles high.
- busy  out  1  registered; 1 whenever state != IDLE.
- data_ack  out  1  registered one-cycle pulse; P_DATA was captured on the preceding edge.

Behaviour:
Reset (rst=1 at a rising edge), effective that edge regardless of state:
- state=IDLE, TX_OUT=1, busy=0, data_ack=0; all counters cleared.
- Any frame in progress is abandoned; there is no partial stop bit.

FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters: bit-time counter cnt (0..ps-1, ps = max(prescale,1)) and data-bit index idx (0..DATA_WIDTH-1).

Accept condition:
- DATA_VALID=1 and (state==IDLE, or state==STOP with cnt==ps-1).
- On the accept edge, latch P_DATA into the shift register, and latch PAR_EN, PAR_TYP and ps.
- Compute the parity bit: ^P_DATA for even, ~^P_DATA for odd.
- Set data_ack=1 for exactly the next cycle.
- Go to START with cnt=0 and TX_OUT=0.
- Input changes after the accept edge have no effect on the frame in flight.

Transitions (a bit-time ends when cnt==ps-1; cnt then resets to 0, otherwise cnt increments):
- START end -> DATA with idx=0. TX_OUT = bit 0.
- DATA end:
  - idx<DATA_WIDTH-1 -> idx+1, TX_OUT = next bit (LSB first).
  - idx==DATA_WIDTH-1 -> PARITY (TX_OUT = parity) if PAR_EN latched, else STOP (TX_OUT = 1).
- PARITY end -> STOP, TX_OUT=1.
- STOP end with accept -> START (back-to-back, no idle gap). Otherwise -> IDLE, TX_OUT=1, busy=0.

Timing:
- The line shows the start bit from the cycle after the accept edge.
- Every bit lasts exactly ps cycles.
- Frame length is (10 or 11)*ps cycles for DATA_WIDTH=8.
- busy rises in the cycle after accept.
- busy stays 1 across back-to-back frames.

Other rules:
- DATA_VALID while busy, outside the STOP last cycle, is ignored. It is not queued, and data_ack stays 0.
- DATA_VALID held high continuously produces consecutive frames, each acknowledged once.
- TX_OUT must be glitch-free: it comes from a flop, not a combinational decode.

Test Plan:
- Basic frame, no parity: prescale=8, PAR_EN=0, P_DATA=0x07, one-cycle DATA_VALID from IDLE -> TX_OUT bits 0,1,1,1,0,0,0,0,0,1, each 8 cycles, total 80 cycles. data_ack pulses once. busy=0 after the stop bit.
- Parity types: prescale=4, P_DATA=0x07, PAR_EN=1.
  - PAR_TYP=0 -> parity bit 1, frame 44 cycles.
  - PAR_TYP=1 -> parity bit 0.
  - Loopback into UART_RX with the same config -> P_DATA_reg=0x07, par_err=0, stp_err=0.
- Back-to-back: prescale=16, DATA_VALID held high with P_DATA=0xA5 then 0x3C (changed after the first data_ack) -> two frames with no idle cycle between the first stop bit and the second start bit. Two data_ack pulses, 176 cycles apart with PAR_EN=0 being 160. busy stays high throughout.
- Ignored request and config change mid-frame: during a 0x55 frame at prescale=8, pulse DATA_VALID with 0xFF and change prescale to 4 and PAR_EN to 1 -> current frame unchanged at 8 cycles/bit with no parity. No data_ack for 0xFF.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 -> TX_OUT=1, busy=0, data_ack=0 on that edge. A new request afterwards produces a full, correct frame.
- Prescale sweep: random P_DATA/PAR_EN/PAR_TYP at prescale 4, 8, 16, 32, plus prescale=0 (treated as 1) -> bit durations exact. Scoreboard against UART_RX output shows zero mismatches over 100 frames.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop; ps clocks per bit.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  data_ack
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [PRESCALE_W-1:0] cnt, cnt_n, ps_q, ps_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  par_en_q, par_en_n, par_bit, par_bit_n;
  logic                  tx_n, busy_n, ack_n;
  logic                  bit_end, accept;

  always_comb begin
    bit_end   = (cnt == ps_q - PRESCALE_W'(1));
    accept    = DATA_VALID && ((state == IDLE) || ((state == STOP) && bit_end));
    state_n   = state;
    cnt_n     = bit_end ? '0 : cnt + PRESCALE_W'(1);
    idx_n     = idx;
    sh_n      = sh;
    ps_n      = ps_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit;
    tx_n      = TX_OUT;
    ack_n     = 1'b0;

    // sh[0] always holds the next data bit to put on the line
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = '0;
        tx_n    = sh[0];
        sh_n    = sh >> 1;
      end
      DATA: if (bit_end) begin
        if (idx == IDX_LAST) begin
          state_n = par_en_q ? PARITY : STOP;
          tx_n    = par_en_q ? par_bit : 1'b1;
        end else begin
          idx_n = idx + IDX_W'(1);
          tx_n  = sh[0];
          sh_n  = sh >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // accept overrides the STOP exit so back-to-back frames have no idle gap
    if (accept) begin
      state_n   = START;
      cnt_n     = '0;
      idx_n     = '0;
      tx_n      = 1'b0;
      sh_n      = P_DATA;
      par_en_n  = PAR_EN;
      par_bit_n = PAR_TYP ? ~^P_DATA : ^P_DATA;
      ps_n      = (prescale == '0) ? PRESCALE_W'(1) : prescale;
      ack_n     = 1'b1;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      ps_q     <= PRESCALE_W'(1);
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      data_ack <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      ps_q     <= ps_n;
      par_en_q <= par_en_n;
      par_bit  <= par_bit_n;
      TX_OUT   <= tx_n;
      busy     <= busy_n;
      data_ack <= ack_n;
    end
  end

endmodule
